seg_scan_display: RTL and testbench

Parametrised multiplexed N-digit 7-segment display driver; successor of the single-digit registered hex decoder. Captures a packed hex word plus per-digit decimal points, time-multiplexes it across `DIGITS` common-driven digits with a programmable refresh rate and an anti-ghosting dark guard band, and optionally suppresses leading zeros. Sits between the datapath (which writes values on a strobe) and the board pins. Display updates are frame-synchronous so a digit never shows a mix of old and new values mid-frame.

---
 rtl/seg_scan_display.sv | 162 ++++++++++++++++
 tb/tb_seg_scan_display.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_display
// Brief    : Multiplexed N-digit 7-segment driver, frame-synchronous updates.
// Revision : 1.0
// ============================================================================
module seg_scan_display #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_done
);

  localparam int c_cnt_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS - 1);
  localparam logic [c_cnt_w-1:0] c_guard    = c_cnt_w'(GUARD);

  logic [4*DIGITS-1:0] r_pend_val;
  logic [DIGITS-1:0]   r_pend_dp;
  logic [4*DIGITS-1:0] r_act_val;
  logic [DIGITS-1:0]   r_act_dp;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_idx_w-1:0]  r_idx;
  logic [6:0]          r_raw_seg;
  logic                r_raw_dp;
  logic [DIGITS-1:0]   r_raw_dig;
  logic                r_frame_done;

  logic                w_slot_end;
  logic                w_wrap;
  logic                w_dark;
  logic [3:0]          w_nib;
  logic                w_dp_sel;
  logic [DIGITS-1:0]   w_onehot;
  logic                w_zero_acc;
  logic                w_blank;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  assign w_slot_end = (r_cnt == c_cnt_last);
  assign w_wrap     = enable && w_slot_end && (r_idx == c_idx_last);
  assign w_dark     = !enable || (r_cnt < c_guard);

  // Walk from the most significant digit down so the accumulator tells
  // whether every nibble at or above the current one is zero.
  always_comb begin
    w_nib      = 4'h0;
    w_dp_sel   = 1'b0;
    w_onehot   = '0;
    w_zero_acc = 1'b1;
    w_blank    = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_acc = w_zero_acc && (r_act_val[4*i +: 4] == 4'h0);
      if (r_idx == c_idx_w'(i)) begin
        w_nib       = r_act_val[4*i +: 4];
        w_dp_sel    = r_act_dp[i];
        w_onehot[i] = 1'b1;
        w_blank     = lz_blank && (i != 0) && w_zero_acc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_act_val  <= '0;
      r_act_dp   <= '0;
    end else begin
      if (load) begin
        r_pend_val <= value;
        r_pend_dp  <= dp;
      end
      if (!enable) begin
        r_act_val <= r_pend_val;
        r_act_dp  <= r_pend_dp;
      end else if (w_wrap) begin
        // A load landing on the wrap edge bypasses pending.
        r_act_val <= load ? value : r_pend_val;
        r_act_dp  <= load ? dp    : r_pend_dp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (!enable) begin
        r_cnt <= '0;
        r_idx <= '0;
      end else if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw_seg <= '0;
      r_raw_dp  <= 1'b0;
      r_raw_dig <= '0;
    end else if (w_dark) begin
      r_raw_seg <= '0;
      r_raw_dp  <= 1'b0;
      r_raw_dig <= '0;
    end else begin
      r_raw_seg <= w_blank ? 7'b0 : f_decode(w_nib);
      r_raw_dp  <= w_dp_sel;
      r_raw_dig <= w_onehot;
    end
  end

  // Pin polarity follows mode with no register stage.
  assign seg        = mode ? r_raw_seg : ~r_raw_seg;
  assign seg_dp     = mode ? r_raw_dp  : ~r_raw_dp;
  assign dig        = mode ? ~r_raw_dig : r_raw_dig;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_display
// Brief    : Scoreboard bench for seg_scan_display (4 digits, 8-cycle slots).
// Revision : 1.0
// ============================================================================
module tb_seg_scan_display;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        lz_blank;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  dig;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S6 = 7'b1111101;
  localparam logic [6:0] S7 = 7'b0000111;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] SA = 7'b1110111;
  localparam logic [6:0] SB = 7'b1111100;
  localparam logic [6:0] SC = 7'b0111001;
  localparam logic [6:0] SD = 7'b1011110;
  localparam logic [6:0] SF = 7'b1110001;
  localparam logic [6:0] SX = 7'b0000000;

  typedef struct {
    logic [6:0] seg;
    logic       sdp;
    logic [3:0] dig;
    logic       fd;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  seg_scan_display #(
    .DIGITS      (4),
    .REFRESH_DIV (8),
    .GUARD       (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .dp         (dp),
    .lz_blank   (lz_blank),
    .seg        (seg),
    .seg_dp     (seg_dp),
    .dig        (dig),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry consumed per falling edge while any are queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if ({seg, seg_dp, dig, frame_done} !== {e.seg, e.sdp, e.dig, e.fd}) begin
        n_bad++;
        $display("FAIL %s: got seg=%b dp=%b dig=%b fd=%b, want seg=%b dp=%b dig=%b fd=%b",
                 e.tag, seg, seg_dp, dig, frame_done, e.seg, e.sdp, e.dig, e.fd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected pins from raw (active-high) segment/dp/digit-select values.
  task automatic push_exp(input logic [6:0] rs, input logic rdp, input logic [3:0] rdig,
                          input logic fd, input bit cc, input string tag);
    exp_t e;
    e.seg = cc ? rs : ~rs;
    e.sdp = cc ? rdp : ~rdp;
    e.dig = cc ? ~rdig : rdig;
    e.fd  = fd;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic push_slot(input int d, input logic [6:0] rs, input logic rdp,
                           input bit cc, input string tag);
    logic [3:0] oh;
    oh = 4'b0001 << d;
    for (int c = 0; c < 8; c++) begin
      if (c < 2)
        push_exp(SX, 1'b0, 4'b0000, 1'b0, cc, $sformatf("%s d%0d c%0d", tag, d, c));
      else
        push_exp(rs, rdp, oh, (d == 3 && c == 7), cc, $sformatf("%s d%0d c%0d", tag, d, c));
    end
  endtask

  // Called just after the edge that shows frame position 0; returns just
  // after the edge showing position 31. Optional load set up before the
  // edge that follows shown position load_p.
  task automatic run_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpv,
                           input bit cc, input int load_p, input logic [15:0] lv,
                           input logic [3:0] ldp);
    push_slot(0, s0, dpv[0], cc, tag);
    push_slot(1, s1, dpv[1], cc, tag);
    push_slot(2, s2, dpv[2], cc, tag);
    push_slot(3, s3, dpv[3], cc, tag);
    for (int p = 0; p < 31; p++) begin
      if (p == load_p) begin
        load  = 1'b1;
        value = lv;
        dp    = ldp;
      end
      tick();
      load = 1'b0;
    end
  endtask

  task automatic wait_frame_done(input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (frame_done) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL sync: frame_done not seen within %0d cycles, want a pulse", budget);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    mode     = 1'b1;
    enable   = 1'b1;
    load     = 1'b0;
    value    = 16'h0000;
    dp       = 4'b0000;
    lz_blank = 1'b0;

    // Reset state in both polarities.
    #2;
    push_exp(SX, 1'b0, 4'b0000, 1'b0, 1'b1, "reset cc");
    @(negedge clk); #1;
    mode = 1'b0;
    push_exp(SX, 1'b0, 4'b0000, 1'b0, 1'b0, "reset ca");
    @(negedge clk); #1;
    mode  = 1'b1;
    rst_n = 1'b1;
    load  = 1'b1;
    value = 16'h1234;
    tick();
    load = 1'b0;
    wait_frame_done(100);

    // Common-cathode scan and frame_done cadence.
    tick(); run_frame("F1", S4, S3, S2, S1, 4'b0000, 1'b1, -1, 16'h0, 4'b0);
    tick(); run_frame("F2", S4, S3, S2, S1, 4'b0000, 1'b1, -1, 16'h0, 4'b0);
    // Mid-frame load is held until the wrap.
    tick(); run_frame("F3", S4, S3, S2, S1, 4'b0000, 1'b1, 16, 16'hABCD, 4'b0);
    // Load on the wrap edge shows in the very next frame.
    tick(); run_frame("F4", SD, SC, SB, SA, 4'b0000, 1'b1, 30, 16'h5678, 4'b0);
    lz_blank = 1'b1;
    tick(); run_frame("F5", S8, S7, S6, S5, 4'b0000, 1'b1, 30, 16'h0040, 4'b0);
    tick(); run_frame("F6", S0, S4, SX, SX, 4'b0000, 1'b1, 30, 16'h0000, 4'b0);
    tick(); run_frame("F7", S0, SX, SX, SX, 4'b0000, 1'b1, -1, 16'h0, 4'b0);
    lz_blank = 1'b0;
    tick(); run_frame("F8", S0, S0, S0, S0, 4'b0000, 1'b1, 30, 16'h00F0, 4'b0001);
    @(negedge clk); #1;
    mode = 1'b0;
    tick(); run_frame("F9", S0, SF, S0, S0, 4'b0001, 1'b0, -1, 16'h0, 4'b0);
    @(negedge clk); #1;
    mode = 1'b1;

    // Disable while digit 2 is being scanned, then re-enable.
    tick();
    push_slot(0, S0, 1'b1, 1'b1, "D");
    push_slot(1, SF, 1'b0, 1'b1, "D");
    repeat (15) tick();
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      push_exp(SX, 1'b0, 4'b0000, 1'b0, 1'b1, $sformatf("disabled %0d", k));
    end
    enable = 1'b1;
    tick();
    push_slot(0, S0, 1'b1, 1'b1, "RE");
    repeat (7) tick();

    // Pending 0x0009, then asynchronous reset mid-slot.
    load  = 1'b1;
    value = 16'h0009;
    dp    = 4'b0000;
    tick();
    load = 1'b0;
    push_exp(SX, 1'b0, 4'b0000, 1'b0, 1'b1, "pre-rst d1 c0");
    tick();
    push_exp(SX, 1'b0, 4'b0000, 1'b0, 1'b1, "pre-rst d1 c1");
    tick();
    rst_n = 1'b0;
    push_exp(SX, 1'b0, 4'b0000, 1'b0, 1'b1, "async reset dark");
    tick();
    push_exp(SX, 1'b0, 4'b0000, 1'b0, 1'b1, "reset held");
    rst_n = 1'b1;
    tick(); run_frame("R1", S0, S0, S0, S0, 4'b0000, 1'b1, -1, 16'h0, 4'b0);
    tick(); run_frame("R2", S0, S0, S0, S0, 4'b0000, 1'b1, -1, 16'h0, 4'b0);

    @(negedge clk); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
